// File: rtl/multicore_run_sequencer.sv
// Run sequencer: resets a group of cores, lets them run until all halt or a cycle
// limit expires, repeats the run NUM_RUNS times and compares results against run 0.
module multicore_run_sequencer #(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned RUN_CYCLES = 500,
  parameter int unsigned NUM_RUNS   = 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [NUM_CORES-1:0]        CoreHalt,
  input  logic [NUM_CORES*DATA_W-1:0] CoreResult,
  output logic                        CoreReset,
  output logic                        Busy,
  output logic                        Done,
  output logic [3:0]                  RunIdx,
  output logic [NUM_CORES*DATA_W-1:0] Captured,
  output logic                        Mismatch,
  output logic [3:0]                  TimeoutCount,
  output logic [31:0]                 CycleCount
);

  localparam int unsigned RES_W     = NUM_CORES * DATA_W;
  localparam int unsigned RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0]     run_cnt;

  logic start_c;
  logic run_end_c;
  logic halted_c;
  logic last_run_c;

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    run_end_c  = 1'b0;
    halted_c   = &CoreHalt;
    last_run_c = (IDX_W'(RunIdx) + IDX_W'(1)) >= IDX_W'(NUM_RUNS);
    case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          start_c   = 1'b1;
          state_nxt = S_RST;
        end
      end
      S_RST: begin
        if (rst_cnt == RST_CNT_W'(RST_CYCLES - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (halted_c || (run_cnt == CNT_W'(RUN_CYCLES))) begin
          run_end_c = 1'b1;
          state_nxt = last_run_c ? S_DONE : S_RST;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      run_cnt      <= '0;
      CoreReset    <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      RunIdx       <= '0;
      Captured     <= '0;
      Mismatch     <= 1'b0;
      TimeoutCount <= '0;
      CycleCount   <= '0;
    end else begin
      state     <= state_nxt;
      CoreReset <= (state_nxt != S_RUN);
      Busy      <= (state_nxt == S_RST) || (state_nxt == S_RUN);
      Done      <= (state_nxt == S_DONE);
      rst_cnt   <= (state == S_RST) ? rst_cnt + RST_CNT_W'(1) : '0;
      // Counter reads 1 during the first RUN cycle
      run_cnt   <= (state == S_RUN) ? run_cnt + CNT_W'(1) : CNT_W'(1);

      if (start_c) begin
        RunIdx       <= '0;
        Mismatch     <= 1'b0;
        TimeoutCount <= '0;
      end

      if (run_end_c) begin
        CycleCount <= run_cnt;
        if (!halted_c && (TimeoutCount != 4'hF)) TimeoutCount <= TimeoutCount + 4'd1;
        if (RunIdx == 4'd0) begin
          Captured <= CoreResult;
        end else if (CoreResult != Captured) begin
          Mismatch <= 1'b1;
        end
        if (!last_run_c) RunIdx <= RunIdx + 4'd1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{RES_W};

endmodule

// File: doc/multicore_run_sequencer.md
MULTICORE_RUN_SEQUENCER -- requirements
Module: multicore_run_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 2, number of cores supervised (legal range 1..8).
REQ-002 The block SHALL have parameter DATA_W, default 32, width of each core result word.
REQ-003 The block SHALL have parameter RST_CYCLES, default 4, core reset hold length in cycles (at least 1).
REQ-004 The block SHALL have parameter RUN_CYCLES, default 500, maximum run length in cycles (at least 1).
REQ-005 The block SHALL have parameter NUM_RUNS, default 2, runs per Start (legal range 1..15).
REQ-006 The block SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-008 The block SHALL have port Start  input  1  request a test sequence; sampled only in IDLE or DONE.
REQ-009 The block SHALL have port CoreHalt  input  NUM_CORES  per-core halted flag.
REQ-010 The block SHALL have port CoreResult  input  NUM_CORES*DATA_W  core k result at bits [k*DATA_W +: DATA_W].
REQ-011 The block SHALL have port CoreReset  output  1  reset to all cores.
REQ-012 The block SHALL have port Busy  output  1  sequence in progress.
REQ-013 The block SHALL have port Done  output  1  sequence complete; level output, held until next Start or Reset.
REQ-014 The block SHALL have port RunIdx  output  4  index of the current or last run, 0-based.
REQ-015 The block SHALL have port Captured  output  NUM_CORES*DATA_W  results latched at the end of run 0.
REQ-016 The block SHALL have port Mismatch  output  1  sticky; a later run ended with results differing from Captured.
REQ-017 The block SHALL have port TimeoutCount  output  4  number of runs ended by the cycle limit.
REQ-018 The block SHALL have port CycleCount  output  32  RUN-state cycles of the most recent run.

Function
REQ-019 The block SHALL implement states IDLE, RST, RUN and DONE.
REQ-020 In IDLE and DONE, Start=1 SHALL cause the following on that edge: move to RST; clear RunIdx, Mismatch, TimeoutCount and Done; set Busy=1.
REQ-021 Start SHALL be ignored while Busy=1.
REQ-022 CoreReset SHALL be 1 in IDLE, RST and DONE, and 0 only in RUN.
REQ-023 RST SHALL last exactly RST_CYCLES cycles, then move to RUN; Start sampled at edge n gives first RUN cycle at n+1+RST_CYCLES.
REQ-024 In RUN, an internal counter SHALL count cycles from 1; the run ends on the cycle where &CoreHalt=1 or the count equals RUN_CYCLES.
REQ-025 If all-halt and the limit coincide, the run SHALL count as halted; TimeoutCount is not incremented.
REQ-026 On a limit-only end, TimeoutCount SHALL increment, saturating at 15.
REQ-027 On the run-ending edge, the block SHALL sample CoreResult: run 0 loads Captured; later runs set Mismatch if any bit differs from Captured.
REQ-028 On the same edge, CycleCount SHALL load the final counter value.
REQ-029 After a run ends: if RunIdx+1 < NUM_RUNS, RunIdx SHALL increment and the block SHALL enter RST; otherwise the block SHALL enter DONE with Done=1 and Busy=0.
REQ-030 CoreHalt and CoreResult SHALL be ignored outside RUN.
REQ-031 NUM_RUNS=1 SHALL never set Mismatch.

Reset
REQ-032 Reset=1 SHALL force IDLE on the next edge from any state, aborting any run immediately.
REQ-033 Reset SHALL give CoreReset=1, Busy=0, Done=0, RunIdx=0, Captured=0, Mismatch=0, TimeoutCount=0, CycleCount=0.
REQ-034 Reset SHALL take priority over Start on the same edge.

Verification (RST_CYCLES=4, RUN_CYCLES=20, NUM_RUNS=2, NUM_CORES=2, DATA_W=32)
REQ-035 The bench SHALL cover: Start, CoreHalt=2'b11 at RUN cycle 10 both runs, CoreResult={32'h5,32'h7} -> CycleCount=10, Captured={5,7}, Mismatch=0, TimeoutCount=0, Done=1.
REQ-036 The bench SHALL cover: CoreHalt held 2'b01 throughout -> each run lasts 20 cycles, TimeoutCount=2, CycleCount=20.
REQ-037 The bench SHALL cover: run 1 result differs (core 1 = 32'h8) -> Mismatch=1, Captured unchanged {5,7}.
REQ-038 The bench SHALL cover: all-halt on RUN cycle 20 -> TimeoutCount=0, CycleCount=20.
REQ-039 The bench SHALL cover: Reset asserted at RUN cycle 5 of run 1 -> next cycle IDLE, all outputs at reset values, CoreReset=1.
REQ-040 The bench SHALL cover: Start pulsed mid-RUN -> no effect; Start in DONE -> new sequence, Done=0, Mismatch cleared.
